brc_iter: RTL
=============

BRC_ITER -- requirements
Module: brc_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 8, meaning bits compared per cycle; WIDTH % DIGIT == 0 and DIGIT >= 1 SHALL be checked at elaboration.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 rs1_data  input  WIDTH  operand A.
REQ-008 rs2_data  input  WIDTH  operand B.
REQ-009 br_op  input  3  branch op: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; br_op[1] selects unsigned.
REQ-010 flush  input  1  abort the in-flight comparison.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 br_less  output  1  A < B under the signedness of br_op (BEQ/BNE: signed).
REQ-014 br_equal  output  1  A == B.
REQ-015 br_taken  output  1  branch decision for br_op; codes 010/011 SHALL give br_taken=0.

Function
REQ-016 FSM states: IDLE, CMP, DONE; in_ready=1 only in IDLE and rst=0.
REQ-017 IDLE: in_valid&&in_ready captures operands and br_op, with sign bits inverted when signed, clears digit index k to 0, and moves to CMP.
REQ-018 CMP: each cycle compares digit k (k=0 is MSB digit) of the captured operands as unsigned values.
REQ-019 A differing digit SHALL set br_less from that digit, set br_equal=0, and move to DONE at the next edge.
REQ-020 If digit N-1 (N=WIDTH/DIGIT) is equal, the FSM SHALL set br_equal=1, br_less=0, and move to DONE.
REQ-021 Latency from the accept edge to out_valid high SHALL be k+1 cycles for the first differing digit k, or N cycles when the operands are equal.
REQ-022 DONE: out_valid=1; br_less, br_equal and br_taken SHALL be registered and held stable until out_valid&&out_ready, after which the FSM returns to IDLE.
REQ-023 There is no overlap: a new request is accepted no earlier than the cycle after the result handshake.
REQ-024 flush in CMP or DONE SHALL return the FSM to IDLE at the next edge with out_valid=0 and no result delivered.
REQ-025 flush in IDLE with in_valid=1: flush wins and no capture occurs.
REQ-026 Inputs rs1_data, rs2_data and br_op are don't-care outside the accept cycle.

Reset
REQ-027 rst=1 SHALL force IDLE, k=0, out_valid=0, br_less=0, br_equal=0, br_taken=0 and in_ready=0; rst dominates flush and all handshakes.
REQ-028 Reset mid-comparison SHALL discard the request with no out_valid pulse.
REQ-029 in_ready SHALL read 1 in the first cycle after rst deasserts.

Configuration
REQ-030 The block SHALL support macro BRC_EARLY_EXIT_EN; when defined, CMP terminates at the first differing digit as in REQ-019.
REQ-031 Without BRC_EARLY_EXIT_EN, CMP SHALL always run N cycles; the first differing digit decides the result and the latency is a constant N.

Structure
REQ-032 Package brc_pkg SHALL hold the br_op_e enum (the six codes) and the brc_state_e enum (IDLE/CMP/DONE).
REQ-033 Sub-module brc_digit_cmp (combinational, DIGIT-bit inputs, outputs lt/eq) SHALL be used for the per-cycle compare.

Verification
REQ-034 Use WIDTH=32, DIGIT=8, EN defined. Stimulus: BLT 0xFFFFFFFF vs 0x00000001. Response: less=1, equal=0, taken=1, out_valid 1 cycle after accept.
REQ-035 Stimulus: BLTU with the same operands. Response: less=0, taken=0, latency 1; with BGEU, taken=1.
REQ-036 Stimulus: BEQ 0x12345678 vs 0x12345678. Response: equal=1, less=0, taken=1, latency 4; with BNE, taken=0.
REQ-037 Stimulus: BGE 0x12345600 vs 0x12345678. Response: less=1, taken=0, latency 4.
REQ-038 Stimulus: out_ready held 0 for 3 cycles in DONE. Response: outputs stable, in_ready=0; result handshake on cycle 4, then IDLE.
REQ-039 Stimulus: flush in CMP cycle 1, and separately rst mid-CMP. Response: no out_valid, IDLE next cycle. Rerun with EN undefined: all latencies = 4.

Source files
------------

// File: rtl/brc_pkg.sv
// ============================================================================
// Module   : brc_pkg
// Brief    : Shared types and branch-decision helper for the iterative
//            branch comparator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package brc_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } brc_state_e;

    // Codes 010/011 are not branches and never take.
    function automatic logic brc_taken(input logic [2:0] op, input logic lt, input logic eq);
        case (op)
            BR_BEQ:  return eq;
            BR_BNE:  return !eq;
            BR_BLT:  return lt;
            BR_BGE:  return !lt;
            BR_BLTU: return lt;
            BR_BGEU: return !lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/brc_digit_cmp.sv
// ============================================================================
// Module   : brc_digit_cmp
// Brief    : Combinational unsigned compare of one DIGIT-bit slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module brc_digit_cmp #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o
);

    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);

endmodule

`default_nettype wire

// File: rtl/brc_iter.sv
// ============================================================================
// Module   : brc_iter
// Brief    : Iterative MSB-first branch comparator, DIGIT bits per cycle.
//            Define BRC_EARLY_EXIT_EN to stop at the first differing digit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module brc_iter
    import brc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [2:0]       br_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_less,
    output logic             br_equal,
    output logic             br_taken
);

    localparam int               N         = WIDTH / ((DIGIT < 1) ? 1 : DIGIT);
    localparam int               KW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    K_LAST    = KW'(N - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if ((DIGIT < 1) || ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_param_check
            $error("brc_iter: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    brc_state_e       state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             out_valid_q;
    logic             less_q;
    logic             equal_q;
    logic             taken_q;

    logic             accept_d;
    logic [WIDTH-1:0] sign_sel_d;
    logic             dig_lt_d;
    logic             dig_eq_d;
    logic             last_d;
    logic             fin_lt_d;
    logic             fin_eq_d;

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign accept_d   = in_valid && in_ready && !flush;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_sel_d = br_op[1] ? '0 : SIGN_MASK;

    brc_digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .a_i  (a_q[WIDTH-1 -: DIGIT]),
        .b_i  (b_q[WIDTH-1 -: DIGIT]),
        .lt_o (dig_lt_d),
        .eq_o (dig_eq_d)
    );

`ifdef BRC_EARLY_EXIT_EN
    assign last_d   = !dig_eq_d || (k_q == K_LAST);
    assign fin_lt_d = dig_lt_d;
    assign fin_eq_d = dig_eq_d;
`else
    logic decided_q;
    logic lt_seen_q;

    assign last_d   = (k_q == K_LAST);
    assign fin_lt_d = decided_q ? lt_seen_q : dig_lt_d;
    assign fin_eq_d = !decided_q && dig_eq_d;
`endif

    // Operands shift left each CMP cycle so the active digit is always the top slice.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            a_q  <= rs1_data ^ sign_sel_d;
            b_q  <= rs2_data ^ sign_sel_d;
            op_q <= br_op;
        end else if (state_q == ST_CMP) begin
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            less_q      <= 1'b0;
            equal_q     <= 1'b0;
            taken_q     <= 1'b0;
`ifndef BRC_EARLY_EXIT_EN
            decided_q   <= 1'b0;
            lt_seen_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        state_q   <= ST_CMP;
                        k_q       <= '0;
`ifndef BRC_EARLY_EXIT_EN
                        decided_q <= 1'b0;
                        lt_seen_q <= 1'b0;
`endif
                    end
                end
                ST_CMP: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        k_q <= k_q + KW'(1);
`ifndef BRC_EARLY_EXIT_EN
                        if (!decided_q && !dig_eq_d) begin
                            decided_q <= 1'b1;
                            lt_seen_q <= dig_lt_d;
                        end
`endif
                        if (last_d) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            less_q      <= fin_lt_d;
                            equal_q     <= fin_eq_d;
                            taken_q     <= brc_taken(op_q, fin_lt_d, fin_eq_d);
                        end
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign br_less   = less_q;
    assign br_equal  = equal_q;
    assign br_taken  = taken_q;

endmodule

`default_nettype wire
